// File: rtl/ocimem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ocimem_arb_pkg
// Brief    : Shared types and default widths for the OCI debug-RAM arbiter.
// Revision : 1.0
// ============================================================================
package ocimem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_AV   = 1'b0,
    GNT_JTAG = 1'b1
  } gnt_t;

endpackage
`default_nettype wire

// File: rtl/ocimem_jtag_pend.sv
`default_nettype none
// ============================================================================
// Module   : ocimem_jtag_pend
// Brief    : One-deep JTAG request buffer with sticky overrun flag.
// Revision : 1.0
// ============================================================================
module ocimem_jtag_pend #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_clr,
  output logic              o_pend,
  output logic              o_wr,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_overrun
);

  logic              r_pend;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_overrun;
  logic              w_accept;

  // A strobe landing in the completion cycle refills the slot being freed.
  assign w_accept = i_req & (~r_pend | i_clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend    <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend  <= 1'b1;
        r_wr    <= i_wr;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end else if (i_clr) begin
        r_pend  <= 1'b0;
      end
      if (i_req && !w_accept) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_pend    = r_pend;
  assign o_wr      = r_wr;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ocimem_arbiter
// Brief    : Round-robin arbiter between Avalon and JTAG for the debug RAM.
// Revision : 1.0
// ============================================================================
module ocimem_arbiter
  import ocimem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                av_read,
  input  logic                av_write,
  input  logic [ADDR_W-1:0]   av_address,
  input  logic [DATA_W-1:0]   av_writedata,
  input  logic [DATA_W/8-1:0] av_byteenable,
  output logic                av_waitrequest,
  output logic [DATA_W-1:0]   av_readdata,
  input  logic                jtag_req,
  input  logic                jtag_wr,
  input  logic [ADDR_W-1:0]   jtag_addr,
  input  logic [DATA_W-1:0]   jtag_wdata,
  output logic                jtag_ack,
  output logic [DATA_W-1:0]   jtag_rdata,
  output logic                jtag_overrun,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_be,
  input  logic [DATA_W-1:0]   ram_rdata
);

  state_t              r_state;
  state_t              w_state_nxt;
  gnt_t                r_grant;
  gnt_t                r_last_grant;
  gnt_t                w_gnt_sel;
  logic                w_start;
  logic                w_av_pend;
  logic                w_resp_av;
  logic                w_resp_jtag;
  logic                w_j_pend;
  logic                w_j_wr;
  logic [ADDR_W-1:0]   w_j_addr;
  logic [DATA_W-1:0]   w_j_wdata;
  logic [DATA_W-1:0]   r_jtag_rdata;
  logic                r_ram_en;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic [DATA_W/8-1:0] r_ram_be;

  ocimem_jtag_pend #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pend (
    .clk       (clk),
    .reset     (reset),
    .i_req     (jtag_req),
    .i_wr      (jtag_wr),
    .i_addr    (jtag_addr),
    .i_wdata   (jtag_wdata),
    .i_clr     (w_resp_jtag),
    .o_pend    (w_j_pend),
    .o_wr      (w_j_wr),
    .o_addr    (w_j_addr),
    .o_wdata   (w_j_wdata),
    .o_overrun (jtag_overrun)
  );

  assign w_av_pend   = av_read | av_write;
  assign w_resp_av   = (r_state == RESP) && (r_grant == GNT_AV);
  assign w_resp_jtag = (r_state == RESP) && (r_grant == GNT_JTAG);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_gnt_sel   = GNT_AV;
    case (r_state)
      IDLE: begin
        if (w_av_pend || w_j_pend) begin
          w_start     = 1'b1;
          w_state_nxt = ACC;
          if (w_av_pend && w_j_pend) begin
            w_gnt_sel = (r_last_grant == GNT_JTAG) ? GNT_AV : GNT_JTAG;
          end else if (w_j_pend) begin
            w_gnt_sel = GNT_JTAG;
          end
        end
      end
      ACC:     w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // RAM strobes are launched from IDLE so they are visible during ACC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant      <= GNT_AV;
      r_last_grant <= GNT_JTAG;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_ram_be     <= '0;
      r_jtag_rdata <= '0;
    end else begin
      if (w_start) begin
        r_grant      <= w_gnt_sel;
        r_last_grant <= w_gnt_sel;
        r_ram_en     <= 1'b1;
        if (w_gnt_sel == GNT_AV) begin
          r_ram_we    <= av_write;
          r_ram_addr  <= av_address;
          r_ram_wdata <= av_writedata;
          r_ram_be    <= av_byteenable;
        end else begin
          r_ram_we    <= w_j_wr;
          r_ram_addr  <= w_j_addr;
          r_ram_wdata <= w_j_wdata;
          r_ram_be    <= '1;
        end
      end else begin
        r_ram_en <= 1'b0;
        r_ram_we <= 1'b0;
      end
      if (w_resp_jtag && !w_j_wr) begin
        r_jtag_rdata <= ram_rdata;
      end
    end
  end

  assign av_waitrequest = ~w_resp_av;
  assign av_readdata    = w_resp_av ? ram_rdata : '0;
  assign jtag_ack       = w_resp_jtag;
  assign jtag_rdata     = r_jtag_rdata;
  assign ram_en         = r_ram_en;
  assign ram_we         = r_ram_we;
  assign ram_addr       = r_ram_addr;
  assign ram_wdata      = r_ram_wdata;
  assign ram_be         = r_ram_be;

endmodule
`default_nettype wire

// File: tb/tb_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ocimem_arbiter
// Brief    : Self-checking bench for ocimem_arbiter with a behavioural RAM model.
// Revision : 1.0
// ============================================================================
module tb_ocimem_arbiter;

  logic        clk;
  logic        reset;
  logic        av_read, av_write;
  logic [7:0]  av_address;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic        av_waitrequest;
  logic [31:0] av_readdata;
  logic        jtag_req, jtag_wr;
  logic [7:0]  jtag_addr;
  logic [31:0] jtag_wdata;
  logic        jtag_ack;
  logic [31:0] jtag_rdata;
  logic        jtag_overrun;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] ram_mem [0:255] = '{default: 32'h0};
  logic [31:0] mdl     [0:255] = '{default: 32'h0};

  ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .av_read(av_read), .av_write(av_write), .av_address(av_address),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable),
    .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
    .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_addr(jtag_addr),
    .jtag_wdata(jtag_wdata), .jtag_ack(jtag_ack), .jtag_rdata(jtag_rdata),
    .jtag_overrun(jtag_overrun),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data one cycle after the enable, byte-lane writes.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= ram_mem[ram_addr];
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    av_read = 0; av_write = 0; av_address = 0; av_writedata = 0; av_byteenable = 0;
    jtag_req = 0; jtag_wr = 0; jtag_addr = 0; jtag_wdata = 0;
    step;
    step;
    reset = 1'b0;
  endtask

  task automatic av_access(input logic wr, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] be, output logic [31:0] rd, output logic ok);
    ok = 1'b0;
    rd = '0;
    av_read = ~wr; av_write = wr; av_address = a; av_writedata = d; av_byteenable = be;
    for (int k = 0; k < 10; k++) begin
      step;
      if (!av_waitrequest) begin
        rd = av_readdata;
        ok = 1'b1;
        break;
      end
    end
    av_read = 1'b0;
    av_write = 1'b0;
  endtask

  task automatic jtag_access(input logic wr, input logic [7:0] a, input logic [31:0] d,
                             output logic [31:0] rd, output logic ok);
    ok = 1'b0;
    jtag_req = 1'b1; jtag_wr = wr; jtag_addr = a; jtag_wdata = d;
    step;
    jtag_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (jtag_ack) begin
        ok = 1'b1;
        break;
      end
      step;
    end
    step;
    rd = jtag_rdata;
  endtask

  task automatic test_reset;
    apply_reset;
    n_chk++; if (av_waitrequest !== 1'b1) $display("FAIL reset_waitreq got=%b exp=1", av_waitrequest); else n_pass++;
    n_chk++; if (av_readdata !== 32'h0) $display("FAIL reset_readdata got=%h exp=0", av_readdata); else n_pass++;
    n_chk++; if ({ram_en, ram_we} !== 2'b00) $display("FAIL reset_ram_en_we got=%b exp=00", {ram_en, ram_we}); else n_pass++;
    n_chk++; if ({ram_addr, ram_wdata, ram_be} !== 44'h0) $display("FAIL reset_ram_bus got=%h exp=0", {ram_addr, ram_wdata, ram_be}); else n_pass++;
    n_chk++; if ({jtag_ack, jtag_overrun} !== 2'b00) $display("FAIL reset_jtag_flags got=%b exp=00", {jtag_ack, jtag_overrun}); else n_pass++;
    n_chk++; if (jtag_rdata !== 32'h0) $display("FAIL reset_jtag_rdata got=%h exp=0", jtag_rdata); else n_pass++;
  endtask

  task automatic test_av_read;
    logic [31:0] rd;
    logic ok;
    apply_reset;
    av_access(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, rd, ok);
    step;
    av_read = 1'b1; av_address = 8'h10; av_byteenable = 4'hF;
    n_chk++; if ({av_waitrequest, ram_en} !== 2'b10) $display("FAIL avrd_c0 got=%b exp=10", {av_waitrequest, ram_en}); else n_pass++;
    step;
    n_chk++; if ({ram_en, ram_we, av_waitrequest} !== 3'b101) $display("FAIL avrd_c1_ctl got=%b exp=101", {ram_en, ram_we, av_waitrequest}); else n_pass++;
    n_chk++; if (ram_addr !== 8'h10) $display("FAIL avrd_c1_addr got=%h exp=10", ram_addr); else n_pass++;
    step;
    n_chk++; if (av_waitrequest !== 1'b0) $display("FAIL avrd_c2_wait got=%b exp=0", av_waitrequest); else n_pass++;
    n_chk++; if (av_readdata !== 32'hDEADBEEF) $display("FAIL avrd_c2_data got=%h exp=deadbeef", av_readdata); else n_pass++;
    av_read = 1'b0;
    step;
    n_chk++; if ({av_waitrequest, ram_en} !== 2'b10) $display("FAIL avrd_c3 got=%b exp=10", {av_waitrequest, ram_en}); else n_pass++;
  endtask

  task automatic test_jtag_wr_rd;
    logic got;
    int extra;
    apply_reset;
    jtag_req = 1'b1; jtag_wr = 1'b1; jtag_addr = 8'h05; jtag_wdata = 32'h12345678;
    step;
    jtag_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (jtag_ack) got = 1'b1; else step;
    end
    n_chk++; if (got !== 1'b1) $display("FAIL jtag_wr_ack got=%b exp=1", got); else n_pass++;
    // Follow-up read issued in the very cycle the write completes.
    jtag_req = 1'b1; jtag_wr = 1'b0; jtag_addr = 8'h05;
    step;
    jtag_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (jtag_ack) got = 1'b1; else step;
    end
    n_chk++; if (got !== 1'b1) $display("FAIL jtag_rd_ack got=%b exp=1", got); else n_pass++;
    step;
    n_chk++; if (jtag_rdata !== 32'h12345678) $display("FAIL jtag_rdata got=%h exp=12345678", jtag_rdata); else n_pass++;
    n_chk++; if (jtag_overrun !== 1'b0) $display("FAIL jtag_b2b_overrun got=%b exp=0", jtag_overrun); else n_pass++;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      if (jtag_ack) extra++;
      step;
    end
    n_chk++; if (extra !== 0) $display("FAIL jtag_extra_acks got=%0d exp=0", extra); else n_pass++;
  endtask

  task automatic test_tie;
    logic order [0:5];
    int n;
    apply_reset;
    av_write = 1'b1; av_address = 8'h40; av_writedata = 32'h0A0A0A0A; av_byteenable = 4'hF;
    jtag_req = 1'b1; jtag_wr = 1'b1; jtag_addr = 8'h80; jtag_wdata = 32'h0B0B0B0B;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      step;
      jtag_req = 1'b0;
      if (ram_en) begin
        order[n] = (ram_addr == 8'h80);
        n++;
      end
      if (jtag_ack) jtag_req = 1'b1;
    end
    av_write = 1'b0;
    jtag_req = 1'b0;
    n_chk++; if (n !== 6) $display("FAIL tie_grant_count got=%0d exp=6", n); else n_pass++;
    for (int i = 0; i < n; i++) begin
      n_chk++;
      if (order[i] !== logic'(i % 2)) $display("FAIL tie_order[%0d] got_jtag=%b exp_jtag=%0d", i, order[i], i % 2);
      else n_pass++;
    end
  endtask

  task automatic test_byte_write;
    logic [31:0] rd;
    logic ok;
    apply_reset;
    av_access(1'b1, 8'h30, 32'h11223344, 4'hF, rd, ok);
    mdl[8'h30] = merge(mdl[8'h30], 32'h11223344, 4'hF);
    step;
    av_write = 1'b1; av_address = 8'h30; av_writedata = 32'hAABBCCDD; av_byteenable = 4'b0010;
    step;
    n_chk++; if ({ram_en, ram_we, ram_be} !== 6'b11_0010) $display("FAIL bytewr_be got=%b exp=110010", {ram_en, ram_we, ram_be}); else n_pass++;
    step;
    n_chk++; if (av_waitrequest !== 1'b0) $display("FAIL bytewr_done got=%b exp=0", av_waitrequest); else n_pass++;
    av_write = 1'b0;
    mdl[8'h30] = merge(mdl[8'h30], 32'hAABBCCDD, 4'b0010);
    step;
    av_access(1'b0, 8'h30, 32'h0, 4'hF, rd, ok);
    n_chk++; if (ok !== 1'b1 || rd !== mdl[8'h30]) $display("FAIL bytewr_readback got=%h ok=%b exp=%h", rd, ok, mdl[8'h30]); else n_pass++;
  endtask

  task automatic test_overrun;
    int acks;
    logic [31:0] rd;
    logic ok;
    apply_reset;
    jtag_req = 1'b1; jtag_wr = 1'b1; jtag_addr = 8'h20; jtag_wdata = 32'h55AA55AA;
    step;
    jtag_addr = 8'h22; jtag_wdata = 32'h99999999;
    step;
    jtag_req = 1'b0;
    n_chk++; if (jtag_overrun !== 1'b1) $display("FAIL overrun_flag got=%b exp=1", jtag_overrun); else n_pass++;
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      if (jtag_ack) acks++;
      step;
    end
    n_chk++; if (acks !== 1) $display("FAIL overrun_acks got=%0d exp=1", acks); else n_pass++;
    av_access(1'b0, 8'h20, 32'h0, 4'hF, rd, ok);
    n_chk++; if (rd !== 32'h55AA55AA) $display("FAIL overrun_first_wr got=%h exp=55aa55aa", rd); else n_pass++;
    av_access(1'b0, 8'h22, 32'h0, 4'hF, rd, ok);
    n_chk++; if (rd !== 32'h0) $display("FAIL overrun_dropped_wr got=%h exp=0", rd); else n_pass++;
    n_chk++; if (jtag_overrun !== 1'b1) $display("FAIL overrun_sticky got=%b exp=1", jtag_overrun); else n_pass++;
  endtask

  task automatic test_reset_acc;
    logic [31:0] rd;
    logic ok;
    int acks;
    jtag_access(1'b0, 8'h05, 32'h0, rd, ok);
    jtag_req = 1'b1; jtag_wr = 1'b1; jtag_addr = 8'h70; jtag_wdata = 32'hCAFEF00D;
    step;
    jtag_req = 1'b0;
    step;
    n_chk++; if (ram_en !== 1'b1) $display("FAIL rstacc_in_acc got=%b exp=1", ram_en); else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++; if ({ram_en, ram_we, ram_addr, ram_wdata, ram_be} !== 46'h0) $display("FAIL rstacc_ram got=%h exp=0", {ram_en, ram_we, ram_addr, ram_wdata, ram_be}); else n_pass++;
    n_chk++; if ({av_waitrequest, av_readdata} !== {1'b1, 32'h0}) $display("FAIL rstacc_av got=%h exp=100000000", {av_waitrequest, av_readdata}); else n_pass++;
    n_chk++; if ({jtag_ack, jtag_overrun, jtag_rdata} !== 34'h0) $display("FAIL rstacc_jtag got=%h exp=0", {jtag_ack, jtag_overrun, jtag_rdata}); else n_pass++;
    step;
    reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      if (jtag_ack) acks++;
      step;
    end
    n_chk++; if (acks !== 0) $display("FAIL rstacc_no_ack got=%0d exp=0", acks); else n_pass++;
    av_access(1'b0, 8'h70, 32'h0, 4'hF, rd, ok);
    n_chk++; if (rd !== 32'h0) $display("FAIL rstacc_abandoned got=%h exp=0", rd); else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] rd, d;
    logic [7:0] a;
    logic [3:0] be;
    logic ok, wr;
    apply_reset;
    for (int i = 0; i < 40; i++) begin
      a  = 8'h60 + 8'($urandom_range(0, 15));
      d  = $urandom;
      be = 4'($urandom_range(1, 15));
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        av_access(wr, a, d, be, rd, ok);
        if (wr) mdl[a] = merge(mdl[a], d, be);
      end else begin
        jtag_access(wr, a, d, rd, ok);
        if (wr) mdl[a] = d;
      end
      n_chk++;
      if (!ok || (!wr && rd !== mdl[a]))
        $display("FAIL rand[%0d] wr=%b addr=%h got=%h ok=%b exp=%h", i, wr, a, rd, ok, mdl[a]);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset;
    test_av_read;
    test_jtag_wr_rd;
    test_tie;
    test_byte_write;
    test_overrun;
    test_reset_acc;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
